// File: rtl/nibble_pkg.sv
// Shared types and constants for the nibble execute sequencer and its ALU.
package nibble_pkg;

   typedef enum logic [2:0] {
      OP_MOV = 3'd0,
      OP_ADD = 3'd1,
      OP_ADC = 3'd2,
      OP_SUB = 3'd3,
      OP_INC = 3'd4,
      OP_NOR = 3'd5
   } op_code_t;

   localparam logic [3:0] S_PASSA = 4'h0;
   localparam logic [3:0] S_NOR   = 4'h1;
   localparam logic [3:0] S_SUB   = 4'h6;
   localparam logic [3:0] S_ADD   = 4'h9;
   localparam logic [3:0] S_PASSB = 4'hA;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Codes 6 and 7 run the sequence without touching registers or flags.
   function automatic logic is_legal(input logic [2:0] code);
      is_legal = (code <= 3'd5);
   endfunction

endpackage

// File: rtl/nibble_exec_if.sv
// Operation request channel between an issuer and the nibble execute sequencer.
interface nibble_exec_if #(
   parameter int NREG = 16,
   parameter int LENW = 2
);
   logic                    op_valid;
   logic                    op_ready;
   logic [2:0]              op_code;
   logic [$clog2(NREG)-1:0] op_dst;
   logic [$clog2(NREG)-1:0] op_src;
   logic [LENW-1:0]         op_len;

   modport master (output op_valid, op_code, op_dst, op_src, op_len, input op_ready);
   modport slave  (input op_valid, op_code, op_dst, op_src, op_len, output op_ready);
endinterface

// File: rtl/alu.sv
// 4-bit ALU: logic mode (m=1) or arithmetic mode (m=0) with carry in/out.
module alu
   import nibble_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       m,
   input  logic [3:0] s,
   input  logic       crin,
   output logic [3:0] f,
   output logic       crout
);
   logic [4:0] sum_s;

   // Function select; logic mode never produces a carry.
   always_comb begin
      sum_s = 5'd0;
      f     = a;
      crout = 1'b0;
      if (m) begin
         case (s)
            S_PASSA: f = a;
            S_NOR:   f = ~(a | b);
            S_PASSB: f = b;
            default: f = a;
         endcase
      end else begin
         case (s)
            S_ADD:   sum_s = {1'b0, a} + {1'b0, b} + {4'd0, crin};
            S_SUB:   sum_s = {1'b0, a} + {1'b0, ~b} + {4'd0, crin};
            S_PASSA: sum_s = {1'b0, a} + {4'd0, crin};
            default: sum_s = {1'b0, a} + {4'd0, crin};
         endcase
         f     = sum_s[3:0];
         crout = sum_s[4];
      end
   end
endmodule

// File: rtl/nibble_exec.sv
// Multi-nibble execute sequencer: walks op_len+1 register nibbles LSB first
// through the ALU, chaining carry, writing back, then reporting flags.
module nibble_exec
   import nibble_pkg::*;
#(
   parameter int NREG = 16,
   parameter int LENW = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   nibble_exec_if.slave            op,
   input  logic                    wr_en,
   input  logic [$clog2(NREG)-1:0] wr_addr,
   input  logic [3:0]              wr_data,
   input  logic [$clog2(NREG)-1:0] rd_addr,
   output logic [3:0]              rd_data,
   output logic                    done,
   output logic                    carry_flag,
   output logic                    zero_flag
);
   localparam int AW = $clog2(NREG);

   logic [3:0]      regs_r [NREG];
   state_t          state_r, state_s;
   logic [2:0]      code_r;
   logic [AW-1:0]   dst_r, src_r, aidx_s, bidx_s;
   logic [LENW-1:0] len_r, idx_r;
   logic            chain_r, zacc_r, ready_r, done_r, carry_flag_r, zero_flag_r;
   logic            accept_s, last_s, legal_s, init_carry_s, final_carry_s;
   logic            alu_m_s, alu_crin_s, alu_crout_s;
   logic [3:0]      alu_sel_s, alu_f_s;

   assign aidx_s  = dst_r + AW'(idx_r);
   assign bidx_s  = src_r + AW'(idx_r);
   assign last_s  = (idx_r == len_r);
   assign legal_s = is_legal(code_r);

   assign op.op_ready = ready_r;
   assign done        = done_r;
   assign carry_flag  = carry_flag_r;
   assign zero_flag   = zero_flag_r;
   assign rd_data     = regs_r[rd_addr];

   // Next-state decode.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (op.op_valid) begin
               state_s  = RUN;
               accept_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) state_s = DONE;
            else        state_s = RUN;
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Carry seeded into the chain at acceptance.
   always_comb begin
      case (op.op_code)
         OP_ADC:         init_carry_s = carry_flag_r;
         OP_SUB, OP_INC: init_carry_s = 1'b1;
         default:        init_carry_s = 1'b0;
      endcase
   end

   // ALU control; outside RUN the ALU sees a benign pass-B with no carry.
   always_comb begin
      alu_m_s    = 1'b1;
      alu_sel_s  = S_PASSB;
      alu_crin_s = 1'b0;
      if (state_r == RUN) begin
         case (code_r)
            OP_MOV: alu_sel_s = S_PASSB;
            OP_ADD, OP_ADC: begin
               alu_m_s    = 1'b0;
               alu_sel_s  = S_ADD;
               alu_crin_s = chain_r;
            end
            OP_SUB: begin
               alu_m_s    = 1'b0;
               alu_sel_s  = S_SUB;
               alu_crin_s = chain_r;
            end
            OP_INC: begin
               alu_m_s    = 1'b0;
               alu_sel_s  = S_PASSA;
               alu_crin_s = chain_r;
            end
            OP_NOR:  alu_sel_s = S_NOR;
            default: alu_sel_s = S_PASSB;
         endcase
      end else begin
         alu_sel_s = S_PASSB;
      end
   end

   assign final_carry_s = alu_m_s ? 1'b0 : alu_crout_s;

   alu u_alu (
      .a     (regs_r[aidx_s]),
      .b     (regs_r[bidx_s]),
      .m     (alu_m_s),
      .s     (alu_sel_s),
      .crin  (alu_crin_s),
      .f     (alu_f_s),
      .crout (alu_crout_s)
   );

   // State, register file, operand latches and flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         for (int k = 0; k < NREG; k++) regs_r[k] <= 4'h0;
         code_r       <= 3'd0;
         dst_r        <= {AW{1'b0}};
         src_r        <= {AW{1'b0}};
         len_r        <= {LENW{1'b0}};
         idx_r        <= {LENW{1'b0}};
         chain_r      <= 1'b0;
         zacc_r       <= 1'b1;
         ready_r      <= 1'b1;
         done_r       <= 1'b0;
         carry_flag_r <= 1'b0;
         zero_flag_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         ready_r <= (state_s == IDLE);
         done_r  <= (state_s == DONE);
         case (state_r)
            IDLE: begin
               if (wr_en) regs_r[wr_addr] <= wr_data;
               if (accept_s) begin
                  code_r  <= op.op_code;
                  dst_r   <= op.op_dst;
                  src_r   <= op.op_src;
                  len_r   <= op.op_len;
                  idx_r   <= {LENW{1'b0}};
                  chain_r <= init_carry_s;
                  zacc_r  <= 1'b1;
               end
            end
            RUN: begin
               if (legal_s) begin
                  regs_r[aidx_s] <= alu_f_s;
                  chain_r        <= final_carry_s;
                  zacc_r         <= zacc_r & (alu_f_s == 4'h0);
               end
               if (last_s) begin
                  if (legal_s) begin
                     carry_flag_r <= final_carry_s;
                     zero_flag_r  <= zacc_r & (alu_f_s == 4'h0);
                  end
               end else begin
                  idx_r <= idx_r + LENW'(1'b1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/nibble_exec.md
Name: nibble_exec

Overview:
- Multi-nibble execute sequencer sitting directly upstream of the 4-bit `alu`; it also consumes the ALU result.
- Holds a 4-bit register file and accepts one operation at a time over a valid/ready handshake.
- Feeds the ALU one nibble per cycle, LSB first, chaining `crout` into the next `crin`, and writes each result nibble back.
- Reports final carry and zero flags, then pulses `done`.

Parameters:
- NREG, 16, number of 4-bit registers; must be a power of 2; register indices wrap modulo NREG.
- LENW, 2, width of `op_len`; operation length is `op_len+1` nibbles, 1..4 at default.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- op_valid  in  1  operation request
- op_ready  out  1  block can accept an operation
- op_code  in  3  operation, see Behaviour
- op_dst  in  $clog2(NREG)  base index of destination / A operand
- op_src  in  $clog2(NREG)  base index of source / B operand
- op_len  in  LENW  nibble count minus 1
- wr_en  in  1  external register load
- wr_addr  in  $clog2(NREG)  load index
- wr_data  in  4  load data
- rd_addr  in  $clog2(NREG)  debug read index
- rd_data  out  4  combinational `reg[rd_addr]`
- done  out  1  one-cycle pulse, operation complete
- carry_flag  out  1  registered carry result
- zero_flag  out  1  registered zero result

Behaviour:
- Reset (clk edge with rst_n=0):
  - state=IDLE, all registers=0, carry_flag=0, zero_flag=0, done=0, op_ready=1.
  - Reset during RUN or DONE aborts the operation; no further writes occur.
- States:
  - IDLE:
    - op_ready=1.
    - On op_valid&op_ready, latch code/dst/src/len, set i=0, chain carry = initial carry (below), zero accumulator=1, go to RUN.
  - RUN:
    - op_ready=0.
    - ALU inputs: a=reg[(dst+i)%NREG], b=reg[(src+i)%NREG], crin=chain carry.
    - Write f to reg[(dst+i)%NREG]; chain carry<=crout; zero acc &= (f==0).
    - If i==len, go to DONE; else i<=i+1.
  - DONE:
    - done=1 for exactly this cycle; op_ready=0.
    - carry_flag and zero_flag update at the entry edge of DONE, so they are valid while done=1.
    - Next state is IDLE.
- Latency: acceptance edge → len+1 RUN cycles → DONE. done is high in cycle len+2 after the acceptance cycle. Back-to-back ops have at most one operation per len+3 cycles.
- Operations (ALU m,s; initial carry):
  - 0 MOV: m=1, s=A (f=b); carry chain forced 0.
  - 1 ADD: m=0, s=9; initial carry 0.
  - 2 ADC: m=0, s=9; initial carry = carry_flag.
  - 3 SUB: m=0, s=6 (a+~b+cin); initial carry 1; final carry 1 means no borrow.
  - 4 INC: m=0, s=0 (a+cin); initial carry 1; b ignored.
  - 5 NOR: m=1, s=1; carry chain forced 0.
  - 6, 7 illegal:
    - Still accepted; sequence runs with no register writes.
    - carry_flag and zero_flag unchanged; done still pulses.
- Flags:
  - carry_flag = carry out of the last nibble; 0 for MOV and NOR.
  - zero_flag = 1 iff every written result nibble was 0.
- Overlapping src/dst ranges use sequential semantics: nibble i reads register state after nibble i-1's write.
- External load:
  - Honoured only in IDLE.
  - When it coincides with op acceptance, the write still lands, before the first RUN read.
  - Ignored in RUN and DONE.
- rd_data reflects register contents after the most recent edge, with no bypass.
- Outputs driven to the ALU are never X: in IDLE and DONE drive m=1, s=A, crin=0.

Decomposition:
- Shared package `nibble_pkg`:
  - op_code enum (OP_MOV..OP_NOR)
  - ALU select constants (S_PASSA=0, S_SUB=6, S_ADD=9, S_NOR=1, S_PASSB=A)
  - state enum (IDLE, RUN, DONE)
- One sub-module instance: the existing `alu`. The register file stays inline as an array.

Test Plan:
- ADD 8-bit: load r0=C, r1=3, r4=9, r5=2; op ADD dst=0 src=4 len=1 → r0=5, r1=6 (0x65); carry=0, zero=0; done in cycle 3 after acceptance.
- SUB borrow: r0=0, r1=1, r2=1, r3=0; SUB dst=0 src=2 len=1 → r1:r0=0x0F, carry=1. Then swap to 0x01-0x10 → 0xF1, carry=0.
- INC wrap with index wrap: r14..r15 and r0..r1 all F; INC dst=14 len=3 → all four 0, carry=1, zero=1; r2 untouched.
- ADC chain: after the previous test (carry=1), ADC dst=4 src=8 len=0 with r4=7, r8=8 → r4=0, carry=1, zero=1. MOV then clears carry to 0.
- NOR and illegal op:
  - NOR dst=0 src=1 len=0, r0=5, r1=2 → r0=8, carry=0.
  - op_code 7 → registers and flags unchanged, done pulses.
- Handshake and reset:
  - op_valid held during RUN → not accepted until IDLE; wr_en during RUN ignored.
  - rst_n=0 in the 2nd RUN cycle of a len=3 ADD → next cycle IDLE, regs 0, flags 0, no done pulse.
